// File: rtl/exe_seq_if.sv
// E-stage bus between the pipeline control and the exe_seq ALU sequencer.
// master = pipeline side, slave = exe_seq.
interface exe_seq_if #(
  parameter int DW = 64
);
  // Handshake: start is a one-cycle request and is sampled only while busy is low.
  // done pulses for one cycle with vale valid. busy is high from the cycle after
  // a MULQ start until its done cycle, and the upstream holds E stalled meanwhile.
  // flush aborts any request or multiply in flight and never produces done.
  logic          start;
  logic          flush;
  logic [3:0]    e_icode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    fun;
  logic          cc_en;
  logic [DW-1:0] vale;
  logic [2:0]    cc;
  logic          done;
  logic          busy;
  logic          err;

  modport master (
    output start, flush, e_icode, alu_a, alu_b, fun, cc_en,
    input  vale, cc, done, busy, err
  );

  modport slave (
    input  start, flush, e_icode, alu_a, alu_b, fun, cc_en,
    output vale, cc, done, busy, err
  );
endinterface

// File: rtl/exe_seq.sv
// Y86-64 execute-stage ALU sequencer: single-cycle OPQ ops, condition codes, and
// an optional shift-add MULQ compiled in when EXE_SEQ_MUL_EN is defined.
module exe_seq #(
  parameter int DW        = 64,
  parameter int MUL_ITERS = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  exe_seq_if.slave   bus,
  output logic       dbg_state
);

  localparam logic [3:0] OPQ = 4'h6;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t        state;
  logic [DW-1:0] vale_q;
  logic [2:0]    cc_q;
  logic          done_q;
  logic          err_q;
  logic          busy_q;

  logic [DW-1:0] alu_res;
  logic          alu_of;
  logic          alu_ok;
  logic          is_opq;

  assign is_opq = (bus.e_icode == OPQ);

  // Result is always B op A; OF only exists for add/subtract.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    alu_ok  = 1'b1;
    case (bus.fun)
      4'd0: begin
        alu_res = bus.alu_b + bus.alu_a;
        alu_of  = (bus.alu_a[DW-1] == bus.alu_b[DW-1]) && (alu_res[DW-1] != bus.alu_b[DW-1]);
      end
      4'd1: begin
        alu_res = bus.alu_b - bus.alu_a;
        alu_of  = (bus.alu_a[DW-1] != bus.alu_b[DW-1]) && (alu_res[DW-1] != bus.alu_b[DW-1]);
      end
      4'd2:    alu_res = bus.alu_b & bus.alu_a;
      4'd3:    alu_res = bus.alu_b ^ bus.alu_a;
      default: alu_ok  = 1'b0;
    endcase
  end

`ifdef EXE_SEQ_MUL_EN
  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITERS - 1);

  logic [DW-1:0]    acc;
  logic [DW-1:0]    mcand;
  logic [DW-1:0]    mplier;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    acc_nx;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      vale_q <= '0;
      cc_q   <= 3'b100;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef EXE_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (alu_ok) begin
              vale_q <= alu_res;
              done_q <= 1'b1;
              if (is_opq && bus.cc_en)
                cc_q <= {(alu_res == '0), alu_res[DW-1], alu_of};
            end
`ifdef EXE_SEQ_MUL_EN
            else if (bus.fun == 4'd4 && is_opq) begin
              acc    <= '0;
              mcand  <= bus.alu_a;
              mplier <= bus.alu_b;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= MUL;
            end
`endif
            else begin
              vale_q <= '0;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
`ifdef EXE_SEQ_MUL_EN
        MUL: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt == LAST) begin
            // Only OPQ icodes enter MUL, so the latched icode needs no storage.
            vale_q <= acc_nx;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
            if (bus.cc_en)
              cc_q <= {(acc_nx == '0), acc_nx[DW-1], 1'b0};
          end else begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vale  = vale_q;
  assign bus.cc    = cc_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
`ifdef EXE_SEQ_MUL_EN
  assign bus.busy  = busy_q;
`else
  assign bus.busy  = 1'b0;
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_exe_seq.sv
// Directed bench for exe_seq; covers the MULQ sequence when EXE_SEQ_MUL_EN is
// defined and the unsupported-MULQ path otherwise.
module tb_exe_seq;

  logic clk;
  logic rst_n;
  logic dbg_state;
  int   n_cmp;
  int   n_err;

  exe_seq_if #(.DW(64)) bus ();

  exe_seq #(.DW(64), .MUL_ITERS(64)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle; outputs are observed afterwards.
  task automatic issue(input logic [3:0] icode, input logic [3:0] fun,
                       input logic [63:0] a, input logic [63:0] b, input logic cc_en);
    bus.start   = 1'b1;
    bus.e_icode = icode;
    bus.fun     = fun;
    bus.alu_a   = a;
    bus.alu_b   = b;
    bus.cc_en   = cc_en;
    step();
    bus.start   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.e_icode = 4'h0;
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.fun     = 4'h0;
    bus.cc_en   = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check("rst_vale", bus.vale, 64'h0);
    check("rst_cc",   64'(bus.cc), 64'h4);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_err",  64'(bus.err), 64'h0);

    // ADDQ positive overflow
    issue(4'h6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    check("add_vale", bus.vale, 64'h8000_0000_0000_0000);
    check("add_cc",   64'(bus.cc), 64'h3);
    check("add_done", 64'(bus.done), 64'h1);
    check("add_err",  64'(bus.err), 64'h0);
    step();
    check("add_done_pulse", 64'(bus.done), 64'h0);

    // SUBQ to zero, then back-to-back ADDQ with CC writes disabled
    issue(4'h6, 4'd1, 64'h5, 64'h5, 1'b1);
    check("sub_vale", bus.vale, 64'h0);
    check("sub_cc",   64'(bus.cc), 64'h4);
    issue(4'h6, 4'd0, 64'h1, 64'h1, 1'b0);
    check("add_nocc_vale", bus.vale, 64'h2);
    check("add_nocc_cc",   64'(bus.cc), 64'h4);
    check("add_nocc_done", 64'(bus.done), 64'h1);

    // ANDQ updates flags; XORQ under a non-OPQ icode leaves them
    issue(4'h6, 4'd2, 64'hFF00, 64'h0FF0, 1'b1);
    check("and_vale", bus.vale, 64'h0F00);
    check("and_cc",   64'(bus.cc), 64'h0);
    issue(4'h5, 4'd3, 64'h1234, 64'h1234, 1'b1);
    check("xor_vale", bus.vale, 64'h0);
    check("xor_cc",   64'(bus.cc), 64'h0);

    // SUBQ overflow: min_neg - 1
    issue(4'h6, 4'd1, 64'h1, 64'h8000_0000_0000_0000, 1'b1);
    check("subov_vale", bus.vale, 64'h7FFF_FFFF_FFFF_FFFF);
    check("subov_cc",   64'(bus.cc), 64'h1);

    // Unsupported function code
    issue(4'h6, 4'd6, 64'h9, 64'h9, 1'b1);
    check("bad_err",  64'(bus.err), 64'h1);
    check("bad_done", 64'(bus.done), 64'h1);
    check("bad_vale", bus.vale, 64'h0);
    check("bad_cc",   64'(bus.cc), 64'h1);
    check("bad_busy", 64'(bus.busy), 64'h0);
    step();
    check("bad_err_pulse", 64'(bus.err), 64'h0);

    // Flush beats start in IDLE
    bus.flush = 1'b1;
    issue(4'h6, 4'd0, 64'h1, 64'h2, 1'b1);
    bus.flush = 1'b0;
    check("fl_idle_done", 64'(bus.done), 64'h0);
    check("fl_idle_vale", bus.vale, 64'h0);
    check("fl_idle_cc",   64'(bus.cc), 64'h1);

`ifdef EXE_SEQ_MUL_EN
    // MULQ 3 * -1, started in cycle T
    issue(4'h6, 4'd4, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("mul_busy_first", 64'(bus.busy), 64'h1);
    check("mul_state", 64'(dbg_state), 64'h1);
    for (int i = 0; i < 63; i++) begin
      step();
      check("mul_busy", 64'(bus.busy), 64'h1);
      check("mul_early_done", 64'(bus.done), 64'h0);
    end
    step();
    check("mul_done", 64'(bus.done), 64'h1);
    check("mul_busy_end", 64'(bus.busy), 64'h0);
    check("mul_vale", bus.vale, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul_cc",   64'(bus.cc), 64'h2);

    // MULQ 7 * 9 flushed in cycle T+20
    issue(4'h6, 4'd4, 64'h7, 64'h9, 1'b1);
    for (int i = 0; i < 19; i++) begin
      step();
      check("mfl_no_done", 64'(bus.done), 64'h0);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("mfl_busy", 64'(bus.busy), 64'h0);
    check("mfl_done", 64'(bus.done), 64'h0);
    check("mfl_vale", bus.vale, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mfl_cc",   64'(bus.cc), 64'h2);
    step();
    issue(4'h6, 4'd0, 64'h1, 64'h2, 1'b1);
    check("mfl_add_done", 64'(bus.done), 64'h1);
    check("mfl_add_vale", bus.vale, 64'h3);
    check("mfl_add_cc",   64'(bus.cc), 64'h0);

    // Reset in the middle of a multiply
    issue(4'h6, 4'd4, 64'h2, 64'h2, 1'b1);
    step();
    step();
    check("mrst_busy_before", 64'(bus.busy), 64'h1);
`else
    // MULQ is unsupported in this build
    issue(4'h6, 4'd4, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("nomul_err",  64'(bus.err), 64'h1);
    check("nomul_done", 64'(bus.done), 64'h1);
    check("nomul_vale", bus.vale, 64'h0);
    check("nomul_cc",   64'(bus.cc), 64'h1);
    check("nomul_busy", 64'(bus.busy), 64'h0);
    issue(4'h6, 4'd0, 64'h1, 64'h2, 1'b1);
    check("nomul_add_vale", bus.vale, 64'h3);
    check("nomul_add_cc",   64'(bus.cc), 64'h0);
`endif

    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vale", bus.vale, 64'h0);
    check("arst_cc",   64'(bus.cc), 64'h4);
    check("arst_busy", 64'(bus.busy), 64'h0);
    check("arst_done", 64'(bus.done), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("arst_after_done", 64'(bus.done), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_seq.md
# exe_seq

Execute-stage ALU sequencer for the Y86-64 pipeline. It takes the operands and function code chosen for the E stage and issues each operation. Single-cycle ops (ADDQ/SUBQ/ANDQ/XORQ) complete in one cycle. The optional MULQ runs as a 64-iteration shift-add sequence, and the block stalls the pipeline while it runs. It owns the condition-code register and gates CC updates on instruction type and downstream exceptions.

## Interface
Parameters:
- DW, 64, datapath width (matches `DATA_BUS`)
- MUL_ITERS, 64, MULQ iteration count (must equal DW)

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  new instruction in E this cycle; sampled only in IDLE
- flush_i  in  1  synchronous abort (mispredict or exception); has priority over start_i
- E_icode_i  in  4  E-stage icode
- aluA_i  in  DW  operand A
- aluB_i  in  DW  operand B
- fun_i  in  4  function: 0 ADDQ, 1 SUBQ, 2 ANDQ, 3 XORQ, 4 MULQ
- cc_en_i  in  1  low when M or W holds an exception; sampled on the completion cycle
- valE_o  out  DW  registered result
- cc_o  out  3  {ZF,SF,OF}
- done_o  out  1  one-cycle pulse, valE_o valid
- busy_o  out  1  MULQ in progress; drives E/D/F stall
- err_o  out  1  one-cycle pulse, unsupported fun_i

## Operation
- States: IDLE and MUL.
- Result is always B op A:
  - ADDQ: B+A
  - SUBQ: B−A
  - ANDQ: B&A
  - XORQ: B^A
  - MULQ: low DW bits of B×A
- Arithmetic is modulo 2^DW.
- Flags:
  - ZF = (result == 0)
  - SF = result[DW−1]
  - OF for ADDQ: A, B same sign and result sign differs
  - OF for SUBQ: A, B signs differ and result sign differs from B
  - OF for ANDQ, XORQ, MULQ: 0
- IDLE, start_i=1, fun_i 0–3: result registered next edge, done_o=1. State stays IDLE. Back-to-back starts every cycle are legal.
- IDLE, start_i=1, fun_i=4, E_icode_i=OPQ (macro on): load registers at the next edge, then go to MUL.
  - acc=0, mcand=aluA_i, mplier=aluB_i, cnt=0
- MUL, each cycle:
  - if mplier[0]: acc += mcand
  - mcand <<= 1; mplier >>= 1; cnt++
  - On the cycle with cnt==MUL_ITERS−1, the edge writes valE_o = final acc, pulses done_o and returns to IDLE.
  - No early termination.
- Unsupported fun_i (5–15, or 4 with the macro off): next edge sets valE_o=0, pulses done_o and err_o; CC unchanged.
- CC write: only on a done_o edge, and only when all hold:
  - the latched icode is OPQ
  - cc_en_i=1 in the completing cycle
  - err_o=0
  - For non-OPQ icodes, valE_o is still produced and CC is left alone.
- flush_i=1:
  - In MUL: return to IDLE next edge; no done_o; valE_o and CC unchanged.
  - In IDLE with start_i: start_i is ignored.
- start_i during MUL is ignored; upstream must hold E stalled while busy_o is high.

## Timing
- Reset (async assert, sync deassert by the system) sets:
  - state=IDLE, valE_o=0, cc_o=3'b100
  - done_o=0, busy_o=0, err_o=0
  - acc, mcand, mplier, cnt = 0
- Single-cycle op started in cycle T: valE_o and done_o valid in cycle T+1.
- MULQ started in cycle T:
  - busy_o=1 for cycles T+1 … T+MUL_ITERS
  - done_o=1 and busy_o=0 in cycle T+MUL_ITERS+1
  - latency 65 for DW=64
- busy_o is registered, with no combinational path from start_i. The stall logic must treat the start cycle of a MULQ as non-stalling.
- Reset asserted mid-MUL: immediate return to reset values; no done_o.

## Configuration
- EXE_SEQ_MUL_EN defined:
  - MUL state, shift-add datapath and MULQ decode are compiled in.
- EXE_SEQ_MUL_EN undefined:
  - MUL state and datapath are removed.
  - busy_o is tied 0.
  - fun_i=4 takes the unsupported path (err_o pulse, valE_o=0).

## Test plan
- Reset: after rst_n_i released, cc_o=3'b100, valE_o=0, done_o=busy_o=err_o=0.
- ADDQ, OPQ, A=0x7FFF_FFFF_FFFF_FFFF, B=1, cc_en_i=1 -> next cycle valE_o=0x8000_0000_0000_0000, cc_o={0,1,1}, done_o pulse.
- SUBQ A=5, B=5, then same cycle after with cc_en_i=0 and ADDQ A=1, B=1 -> first valE_o=0, cc_o={1,0,0}; second valE_o=2, cc_o remains {1,0,0}.
- MULQ (macro on), A=3, B=0xFFFF_FFFF_FFFF_FFFF -> busy_o high 64 cycles, done at T+65, valE_o=0xFFFF_FFFF_FFFF_FFFD, cc_o={0,1,0}.
- MULQ A=7, B=9 with flush_i pulsed at T+20 -> IDLE at T+21, no done_o, valE_o and cc_o hold prior values; a new ADDQ issued at T+22 completes at T+23.
- fun_i=6 (any build), and fun_i=4 with EXE_SEQ_MUL_EN undefined -> err_o and done_o pulse, valE_o=0, cc_o unchanged, busy_o stays 0.
